uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that consumes the one-cycle `BaudTick` strobe from the baud generator and serialises parallel bytes onto a single line. It accepts a byte through a valid/ready handshake from the processor-side output port. It emits one start bit, DATA_BITS data bits LSB-first, optional even parity, and STOP_BITS stop bits. Each bit lasts exactly one `BaudTick` period.

## Interface
Parameters:
- `DATA_BITS`, 8: payload width per frame; legal values 5–8.
- `STOP_BITS`, 1: number of stop bits; legal values 1–2.

Ports:
- `clk`, in, 1: system clock; all state changes on rising edge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `BaudTick`, in, 1: one-`clk`-wide strobe, one per bit period, from the baud generator.
- `tx_data`, in, DATA_BITS: byte to send; sampled on handshake.
- `tx_valid`, in, 1: producer has a byte.
- `tx_ready`, out, 1: block can accept; high only in IDLE.
- `tx`, out, 1: serial line; idle level 1; registered.
- `tx_busy`, out, 1: high in every state except IDLE.
- `tx_done`, out, 1: one-cycle pulse when the frame's last stop bit completes.

## Operation
- States: IDLE → SYNC → START → DATA → [PARITY] → STOP → IDLE.
- IDLE
  - `tx`=1, `tx_ready`=1.
  - When `tx_valid`&&`tx_ready`, latch `tx_data` into the shift register, clear the bit counter, and go to SYNC.
  - A `BaudTick` in the same cycle as acceptance is ignored.
- SYNC: wait for the next `BaudTick`. On it, drive `tx`=0 and enter START. This aligns frame edges to baud boundaries.
- START: on `BaudTick`, drive `tx`=shift[0], shift right, counter=1, and enter DATA.
- DATA: on each `BaudTick`:
  - If counter<DATA_BITS: drive the next bit and increment the counter.
  - Else: drive parity (when enabled) or 1, then go to PARITY or STOP; clear the counter.
- PARITY: on `BaudTick`, drive `tx`=1 and enter STOP.
- STOP: hold `tx`=1. On each `BaudTick` increment the counter. When counter reaches STOP_BITS−1 with a tick, go to IDLE and pulse `tx_done`.
- Parity is even: XOR of all latched data bits. It is computed at latch time and held in a flop.
- Counter width is $clog2(DATA_BITS+1). It never wraps within a frame.
- `tx_valid` while not ready is held off. Data changes while busy have no effect.
- `BaudTick` held high for several cycles is a protocol violation. The block then advances one bit per cycle; this is not guarded.

## Timing
- Reset values:
  - State IDLE.
  - `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
  - Shift register, counter and parity all 0.
- Reset mid-frame: `tx` returns to 1 asynchronously, and the in-flight byte is discarded.
- Accept cycle A: `tx_ready` is low from A+1.
- Start-bit edge: the first `BaudTick` at cycle T>A gives `tx`=0 from T+1.
- Bit k: driven from the cycle after the (k+1)-th tick.
- Frame length: 1+DATA_BITS+P+STOP_BITS tick periods, where P=1 with parity.
- `tx_done` and the return of `tx_ready`: the cycle after the final stop tick. A new byte may be accepted in that same cycle; back-to-back frames then have no extra idle gap beyond the SYNC wait.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state and the parity flop exist, and the frame carries an even-parity bit between data and stop.
- Undefined: the PARITY state and flop are removed, and DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`: the state enum `uart_tx_state_t` (IDLE, SYNC, START, DATA, PARITY, STOP), `UART_IDLE_LEVEL`=1'b1, and the legal DATA_BITS/STOP_BITS bounds. These are shared with the future `uart_rx`.
- No sub-module: the FSM, shift register and counter stay in one module.

## Test plan
- Reset with `rst_n`=0, then release → `tx`=1, `tx_ready`=1, `tx_busy`=0; no `tx_done` for 20 ticks without `tx_valid`.
- Send 0xA5 with the default parameters and no parity → `tx` per tick is 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses once, 10 tick periods after the start edge.
- With `UART_TX_PARITY_EN`:
  - 0x07 → parity bit 1; frame is 11 ticks.
  - 0xA5 → parity bit 0.
- `tx_valid` coincident with `BaudTick` in IDLE → start bit appears only after the following tick.
- Hold `tx_valid` high with 0x3C then 0xC3 → the second byte is accepted the cycle after `tx_done`, and both frames are bit-exact.
- Assert `rst_n`=0 during DATA bit 4 → `tx`=1 immediately; after release the block is in IDLE, and the next byte sent is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line idle level and legal frame bounds.
// Used by uart_tx (optional parity via UART_TX_PARITY_EN) and the future uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  localparam int unsigned UART_DATA_BITS_MIN = 5;
  localparam int unsigned UART_DATA_BITS_MAX = 8;
  localparam int unsigned UART_STOP_BITS_MIN = 1;
  localparam int unsigned UART_STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s), one bit per tick.
// Define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 BaudTick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);

  uart_tx_state_t         state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        tx_d = UART_IDLE_LEVEL;
        // A tick coinciding with acceptance is ignored: SYNC waits for the next one.
        if (tx_valid) begin
          shift_d = tx_data;
          cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          state_d = StSync;
        end
      end
      StSync: begin
        if (BaudTick) begin
          tx_d    = ~UART_IDLE_LEVEL;
          state_d = StStart;
        end
      end
      StStart: begin
        if (BaudTick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = CntW'(1);
          state_d = StData;
        end
      end
      StData: begin
        if (BaudTick) begin
          if (cnt_q < CntW'(DATA_BITS)) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CntW'(1);
          end else begin
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = UART_IDLE_LEVEL;
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (BaudTick) begin
          tx_d    = UART_IDLE_LEVEL;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        tx_d = UART_IDLE_LEVEL;
        if (BaudTick) begin
          if (cnt_q == CntW'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        tx_d    = UART_IDLE_LEVEL;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == StIdle);
  assign tx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of expected line frames checked by a tick-sampling
// monitor, plus per-scenario handshake, timing and reset checks.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int DataBits = 8;
  localparam int StopBits = 1;
  localparam int FrameLen = 1 + DataBits + Par + StopBits;
  localparam int TickDiv  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       BaudTick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, tx_busy, tx_done;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got;
  int          mon_cnt = 0;
  logic        in_frame = 1'b0;
  logic        done_due = 1'b0;
  int          done_cnt = 0;
  int          div = 0;

  uart_tx #(.DATA_BITS(DataBits), .STOP_BITS(StopBits)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .BaudTick(BaudTick),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  // One-cycle tick every TickDiv clocks, updated on the falling edge.
  always @(negedge clk) begin
    div = (div == TickDiv - 1) ? 0 : div + 1;
    BaudTick = (div == 0);
  end

  function automatic logic [15:0] model_frame(input logic [7:0] d);
    logic [15:0] f;
    logic        p;
    f = '1;
    p = 1'b0;
    f[0] = 1'b0;
    for (int i = 0; i < DataBits; i++) begin
      f[1+i] = d[i];
      p = p ^ d[i];
    end
    if (Par == 1) f[1+DataBits] = p;
    return f;
  endfunction

  // Monitor: line value sampled just before each tick edge, i.e. at the end of each bit period.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      in_frame = 1'b0;
      done_due = 1'b0;
    end else begin
      if (tx_done === 1'b1) done_cnt++;
      if (done_due) begin
        done_due = 1'b0;
        checks++;
        if (tx_done !== 1'b1) begin
          failures++;
          $display("FAIL done_timing: tx_done=%b required 1 after final stop tick", tx_done);
        end
      end
      if (in_frame && BaudTick) begin
        got[mon_cnt] = tx;
        mon_cnt++;
        if (mon_cnt == FrameLen) begin
          in_frame = 1'b0;
          done_due = 1'b1;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected: got %h with empty scoreboard", got);
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (got !== e) begin
              failures++;
              $display("FAIL frame_bits: got %b required %b", got, e);
            end
          end
        end
      end else if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1;
        mon_cnt  = 0;
        got      = '1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 400 && tx_ready !== 1'b1; i++) step();
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back(model_frame(d));
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 400 && (exp_q.size() != 0 || in_frame || tx_ready !== 1'b1); i++) step();
    step();
    step();
    checks++;
    if (exp_q.size() != 0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_drain: pending=%0d tx_ready=%b required 0 and 1", name, exp_q.size(),
               tx_ready);
    end
  endtask

  task automatic test_reset();
    int bad;
    int d0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_outputs: tx/ready/busy/done=%b required 1100",
               {tx, tx_ready, tx_busy, tx_done});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      failures++;
      $display("FAIL release_outputs: tx/ready/busy/done=%b required 1100",
               {tx, tx_ready, tx_busy, tx_done});
    end
    bad = 0;
    d0  = done_cnt;
    repeat (20 * TickDiv) begin
      step();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || done_cnt != d0) begin
      failures++;
      $display("FAIL idle_quiet: bad_cycles=%0d done_pulses=%0d required 0 and 0", bad,
               done_cnt - d0);
    end
  endtask

  task automatic test_single(input logic [7:0] d, input string name);
    int d0;
    d0 = done_cnt;
    send_byte(d);
    checks++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: ready=%b busy=%b required 0 and 1", name, tx_ready, tx_busy);
    end
    wait_idle(name);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d required 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_coincident();
    int early;
    for (int i = 0; i < 10 && BaudTick !== 1'b1; i++) step();
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    exp_q.push_back(model_frame(8'h81));
    step();
    tx_valid = 1'b0;
    early = 0;
    for (int i = 0; i < TickDiv; i++) begin
      if (tx !== 1'b1) early++;
      if (i < TickDiv - 1) step();
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL coincident_early: %0d cycles with tx low, required 0", early);
    end
    step();
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL coincident_start: tx=%b required 0 after following tick", tx);
    end
    wait_idle("coincident");
  endtask

  task automatic test_back_to_back();
    int i;
    for (i = 0; i < 400 && tx_ready !== 1'b1; i++) step();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(model_frame(8'h3C));
    exp_q.push_back(model_frame(8'hC3));
    step();
    tx_data = 8'hC3;
    for (i = 0; i < 400 && tx_done !== 1'b1; i++) step();
    checks++;
    if (tx_done !== 1'b1 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_with_done: done=%b ready=%b required 1 and 1", tx_done, tx_ready);
    end
    step();
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: ready=%b required 0 cycle after done", tx_ready);
    end
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid();
    int i;
    send_byte(8'h0F);
    for (i = 0; i < 400 && !(in_frame && mon_cnt == 5); i++) step();
    step();
    step();
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL mid_bit4: tx=%b required 0 for data bit 4", tx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL mid_async_tx: tx=%b required 1 immediately on reset", tx);
    end
    step();
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL mid_idle: ready=%b busy=%b tx=%b required 1 0 1", tx_ready, tx_busy, tx);
    end
    test_single(8'h96, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, "a5");
`ifdef UART_TX_PARITY_EN
    test_single(8'h07, "p07");
    test_single(8'hA5, "pa5");
`endif
    test_coincident();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
